fifo_beat_unpacker: RTL and testbench

- Read-side consumer of the 140-bit clock-crossing FIFO, in the clk_out domain.
- Pops one 140-bit word at a time and slices it into narrow OUT_W-bit beats.
- Beats leave on a valid/ready stream toward the downstream datapath, with dout_last marking the final beat of each word.
- Sustains back-to-back words with no idle cycle between them.

---
 rtl/fifo_beat_unpacker.sv | 109 ++++++++++
 tb/tb_fifo_beat_unpacker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_beat_unpacker.sv
// Read-side unpacker: pops DSIZE-bit words from a show-ahead FIFO and emits OUT_W-bit beats, LSB first.
// Optional macro UNPACK_WORD_CNT_EN adds a saturating 16-bit word_cnt output.
module fifo_beat_unpacker #(
  parameter int DSIZE = 140,
  parameter int OUT_W = 16
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] data_from_fifo,
  output logic             fifo_r_enable,
  output logic [OUT_W-1:0] dout_data,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             dout_ready
`ifdef UNPACK_WORD_CNT_EN
  ,
  output logic [15:0]      word_cnt
`endif
);

  localparam int NBEATS = (DSIZE + OUT_W - 1) / OUT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PAD_W  = NBEATS * OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t             state_q, state_d;
  logic [DSIZE-1:0]   hold_q;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_d;
  logic [PAD_W-1:0]   hold_pad;
  logic               xfer;
  logic               last_xfer;

  // Zero-extend the held word so the final beat pads with zeros when DSIZE % OUT_W != 0.
  always_comb begin
    hold_pad             = '0;
    hold_pad[DSIZE-1:0]  = hold_q;
  end

  always_comb begin
    dout_valid    = (state_q == SEND);
    dout_last     = dout_valid && (beat_cnt == LAST_CNT);
    dout_data     = hold_pad[beat_cnt*OUT_W +: OUT_W];
    xfer          = dout_valid && dout_ready;
    last_xfer     = dout_last && dout_ready;
    fifo_r_enable = !rst && !fifo_empty && ((state_q == EMPTY) || last_xfer);
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt;
    case (state_q)
      EMPTY: begin
        if (fifo_r_enable) begin
          state_d    = SEND;
          beat_cnt_d = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (beat_cnt != LAST_CNT) begin
            beat_cnt_d = beat_cnt + 1'b1;
          end else if (fifo_r_enable) begin
            // Reload on the last-beat edge keeps beats flowing with no bubble.
            beat_cnt_d = '0;
          end else begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = EMPTY;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q  <= EMPTY;
      beat_cnt <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
      if (fifo_r_enable) begin
        hold_q <= data_from_fifo;
      end
    end
  end

`ifdef UNPACK_WORD_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_out) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (last_xfer) begin
      word_cnt <= sat_inc(word_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_beat_unpacker.sv
// Scoreboard bench for fifo_beat_unpacker: a queue-modelled FIFO feeds the DUT, expected beats are queued at push time.
module tb_fifo_beat_unpacker;

  localparam int DSIZE  = 140;
  localparam int OUT_W  = 16;
  localparam int NBEATS = 9;

  logic             clk_out;
  logic             rst;
  logic             fifo_empty;
  logic [DSIZE-1:0] data_from_fifo;
  logic             fifo_r_enable;
  logic [OUT_W-1:0] dout_data;
  logic             dout_valid;
  logic             dout_last;
  logic             dout_ready;
`ifdef UNPACK_WORD_CNT_EN
  logic [15:0]      word_cnt;
`endif

  fifo_beat_unpacker #(.DSIZE(DSIZE), .OUT_W(OUT_W)) dut (
    .clk_out        (clk_out),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .data_from_fifo (data_from_fifo),
    .fifo_r_enable  (fifo_r_enable),
    .dout_data      (dout_data),
    .dout_valid     (dout_valid),
    .dout_last      (dout_last),
    .dout_ready     (dout_ready)
`ifdef UNPACK_WORD_CNT_EN
    ,
    .word_cnt       (word_cnt)
`endif
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  logic [DSIZE-1:0] fifo_q[$];
  logic [16:0]      exp_q[$];
  logic [15:0]      obs_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               pops = 0;
  int               beat_idx = 0;
  int               first_x = -1;
  int               last_x = -1;
  logic [3:0]       rdy_pat = 4'hF;
  logic             rst_d = 1'b0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    logic [NBEATS*OUT_W-1:0] pad;
    pad = '0;
    pad[DSIZE-1:0] = w;
    fifo_q.push_back(w);
    for (int k = 0; k < NBEATS; k++)
      exp_q.push_back({(k == NBEATS - 1), pad[k*OUT_W +: OUT_W]});
  endtask

  function automatic logic [DSIZE-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DSIZE-1:0];
  endfunction

  task automatic drive_inputs();
    fifo_empty     = (fifo_q.size() == 0);
    data_from_fifo = fifo_empty ? '0 : fifo_q[0];
    dout_ready     = rdy_pat[cyc % 4];
  endtask

  // One clock: sample settled outputs before the edge, then apply the FIFO pop after it.
  task automatic step();
    logic        pop;
    logic [16:0] e;
    drive_inputs();
    #1;
    pop = fifo_r_enable;
    if (rst) begin
      check("rst_pop", fifo_r_enable, 1'b0);
      if (rst_d) begin
        check("rst_valid", dout_valid, 1'b0);
        check("rst_data", dout_data, '0);
        check("rst_last", dout_last, 1'b0);
      end
    end else begin
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1'b1);
        check("stall_data", dout_data, prev_data);
        check("stall_last", dout_last, prev_last);
      end
      if (fifo_r_enable) begin
        check("pop_nonempty", fifo_empty, 1'b0);
        if (dout_valid) check("pop_on_last_xfer", dout_last && dout_ready, 1'b1);
      end
      if (dout_valid && dout_ready) begin
        check("exp_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", dout_data, e[15:0]);
          check("beat_last", dout_last, e[16]);
        end
        obs_q.push_back(dout_data);
        if (first_x < 0) first_x = cyc;
        last_x   = cyc;
        beat_idx = dout_last ? 0 : beat_idx + 1;
      end
    end
    prev_stall = !rst && dout_valid && !dout_ready;
    prev_data  = dout_data;
    prev_last  = dout_last;
    rst_d      = rst;
    @(posedge clk_out);
    #1;
    if (pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      step();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic new_test(input logic [3:0] pat);
    rdy_pat = pat;
    pops    = 0;
    first_x = -1;
    last_x  = -1;
    obs_q.delete();
  endtask

  initial begin
    logic [143:0] inc;
    int           n;
    rst            = 1'b1;
    fifo_empty     = 1'b1;
    data_from_fifo = '0;
    dout_ready     = 1'b1;

    // Reset with a word already waiting: no pop, outputs idle.
    for (int i = 0; i < 18; i++) inc[i*8 +: 8] = 8'(i);
    push_word(inc[DSIZE-1:0]);
    for (int i = 0; i < 4; i++) step();

    // Single word of incrementing bytes, always ready.
    new_test(4'hF);
    rst = 1'b0;
    drive_inputs();
    #1;
    check("pop_after_rst", fifo_r_enable, 1'b1);
    drain(40);
    check("t1_pops", pops, 1);
    check("t1_beats", obs_q.size(), NBEATS);
    if (obs_q.size() == NBEATS) begin
      check("t1_beat0", obs_q[0], 16'h0100);
      check("t1_beat1", obs_q[1], 16'h0302);
      check("t1_beat8", obs_q[8], 16'h0110);
    end
    check("t1_idle", dout_valid, 1'b0);

    // Three words back to back: 27 consecutive beats.
    new_test(4'hF);
    for (int i = 0; i < 3; i++) push_word(rand_word());
    drain(80);
    check("t2_pops", pops, 3);
    check("t2_span", last_x - first_x + 1, 3 * NBEATS);
    check("t2_idle", dout_valid, 1'b0);

    // Backpressure pattern 1,0,0,1.
    new_test(4'b1001);
    for (int i = 0; i < 3; i++) push_word(rand_word());
    drain(200);
    check("t3_pops", pops, 3);
    check("t3_beats", obs_q.size(), 3 * NBEATS);

    // Reset while beat 4 of a word is showing; that word is dropped.
    new_test(4'hF);
    push_word(rand_word());
    push_word(rand_word());
    n = 0;
    while (beat_idx != 4 && n < 50) begin
      step();
      n++;
    end
    check("t4_reach_beat4", beat_idx, 4);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = beat_idx; i < NBEATS; i++)
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    beat_idx = 0;
`ifdef UNPACK_WORD_CNT_EN
    check("t4_word_cnt", word_cnt, 16'd0);
`endif
    drain(40);
    check("t4_fifo_drained", fifo_q.size(), 0);

    // Five words with mixed backpressure.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    new_test(4'b1101);
    for (int i = 0; i < 5; i++) push_word(rand_word());
    drain(300);
    check("t5_pops", pops, 5);
`ifdef UNPACK_WORD_CNT_EN
    check("t5_word_cnt", word_cnt, 16'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
